// File: rtl/count_decoder.sv
// Decodes successive samples of an external 4-bit up/down counter into step pulses.
// It also tracks a saturating signed position and drops lock after repeated illegal jumps.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | no reference sample yet; the next valid sample only seeds prev
// S_LOCKED | tracking; legal steps pulse and move position
// S_LOST   | too many consecutive illegal steps; any legal step relocks
module count_decoder #(
    parameter int unsigned MAX_ERR = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [3:0]        count_in,
    input  logic              clr_pos,
    output logic              up_pls,
    output logic              dn_pls,
    output logic              hold_pls,
    output logic              wrap_up,
    output logic              wrap_dn,
    output logic              step_err,
    output logic signed [7:0] position,
    output logic              locked,
    output logic [3:0]        err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOCKED = 2'd1,
        S_LOST   = 2'd2
    } state_t;

    localparam logic [4:0]        MAX_ERR_C = 5'(MAX_ERR);
    localparam logic signed [7:0] POS_MAX   = 8'sd127;
    localparam logic signed [7:0] POS_MIN   = -8'sd128;

    state_t            state_q, state_d;
    logic [3:0]        prev_q, prev_d;
    logic [3:0]        consec_q, consec_d;
    logic signed [7:0] position_q, position_d;
    logic [3:0]        err_cnt_q, err_cnt_d;
    logic              locked_q, locked_d;
    logic              up_q, up_d;
    logic              dn_q, dn_d;
    logic              hold_q, hold_d;
    logic              wrap_up_q, wrap_up_d;
    logic              wrap_dn_q, wrap_dn_d;
    logic              step_err_q, step_err_d;

    logic [3:0] delta;
    logic       legal;
    logic       consec_hit;

    always_comb begin
        delta      = count_in - prev_q;
        legal      = (delta == 4'd0) || (delta == 4'd1) || (delta == 4'd15);
        consec_hit = ({1'b0, consec_q} + 5'd1) >= MAX_ERR_C;

        state_d    = state_q;
        prev_d     = prev_q;
        consec_d   = consec_q;
        position_d = position_q;
        err_cnt_d  = err_cnt_q;
        up_d       = 1'b0;
        dn_d       = 1'b0;
        hold_d     = 1'b0;
        wrap_up_d  = 1'b0;
        wrap_dn_d  = 1'b0;
        step_err_d = 1'b0;

        if (valid) begin
            // prev follows every accepted sample, legal or not
            prev_d = count_in;
            case (state_q)
                S_IDLE: begin
                    state_d  = S_LOCKED;
                    consec_d = 4'd0;
                end
                S_LOCKED: begin
                    if (delta == 4'd0) begin
                        hold_d   = 1'b1;
                        consec_d = 4'd0;
                    end else if (delta == 4'd1) begin
                        up_d      = 1'b1;
                        wrap_up_d = (prev_q == 4'd15);
                        consec_d  = 4'd0;
                        if (position_q != POS_MAX) position_d = position_q + 8'sd1;
                    end else if (delta == 4'd15) begin
                        dn_d      = 1'b1;
                        wrap_dn_d = (prev_q == 4'd0);
                        consec_d  = 4'd0;
                        if (position_q != POS_MIN) position_d = position_q - 8'sd1;
                    end else begin
                        step_err_d = 1'b1;
                        if (err_cnt_q != 4'd15) err_cnt_d = err_cnt_q + 4'd1;
                        if (consec_hit) begin
                            state_d  = S_LOST;
                            consec_d = 4'd0;
                        end else begin
                            consec_d = consec_q + 4'd1;
                        end
                    end
                end
                S_LOST: begin
                    if (legal) begin
                        state_d = S_LOCKED;
                    end else begin
                        step_err_d = 1'b1;
                        if (err_cnt_q != 4'd15) err_cnt_d = err_cnt_q + 4'd1;
                    end
                    consec_d = 4'd0;
                end
                default: begin
                    state_d  = S_IDLE;
                    consec_d = 4'd0;
                end
            endcase
        end

        // a clear beats any step landing in the same cycle; the pulse still goes out
        if (clr_pos) position_d = 8'sd0;

        locked_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prev_q     <= 4'd0;
            consec_q   <= 4'd0;
            position_q <= 8'sd0;
            err_cnt_q  <= 4'd0;
            locked_q   <= 1'b0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
            hold_q     <= 1'b0;
            wrap_up_q  <= 1'b0;
            wrap_dn_q  <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            consec_q   <= consec_d;
            position_q <= position_d;
            err_cnt_q  <= err_cnt_d;
            locked_q   <= locked_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
            hold_q     <= hold_d;
            wrap_up_q  <= wrap_up_d;
            wrap_dn_q  <= wrap_dn_d;
            step_err_q <= step_err_d;
        end
    end

    assign up_pls   = up_q;
    assign dn_pls   = dn_q;
    assign hold_pls = hold_q;
    assign wrap_up  = wrap_up_q;
    assign wrap_dn  = wrap_dn_q;
    assign step_err = step_err_q;
    assign position = position_q;
    assign locked   = locked_q;
    assign err_cnt  = err_cnt_q;

endmodule
